// File: rtl/divider_restoring_pkg.sv
// Shared arithmetic definitions for the restoring divider.
// Provides the FSM state encoding, the default operand width and a helper
// that builds the all-ones quotient reported for a zero divisor.
package divider_restoring_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MAX_WIDTH     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // All-ones value of the requested width, zero-extended to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/divider_restoring_subtractor_borrow.sv
// Ripple subtractor: diff = a - b, borrow_out = 1 when a < b (unsigned).
// Built as a ripple adder of a + ~b + 1; borrow is the inverted carry-out.
// Ports:
//   a, b        : WIDTH-bit operands
//   diff        : WIDTH-bit difference (modulo 2**WIDTH)
//   borrow_out  : 1 when the subtraction wrapped
module subtractor_borrow #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign borrow_out = ~carry[WIDTH];

endmodule

// One-bit full adder cell shared with the ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/divider_restoring.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor finishes one cycle after
// acceptance instead of running the full WIDTH iterations.
// Ports:
//   clock, resetn        : rising-edge clock, async active-low reset
//   start                : request; accepted in IDLE or DONE
//   dividend, divisor    : operands, captured on acceptance
//   busy                 : high while a division is in flight
//   done                 : one-cycle pulse when results update
//   quotient, remainder  : last completed result, held until the next one
//   div_by_zero          : divisor of the current result was zero
module divider_restoring
    import divider_restoring_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] divisor_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;
    logic             borrow_c;
    logic [WIDTH:0]   r_next_c;
    logic [WIDTH-1:0] q_next_c;

    // R[WIDTH] only guards the trial subtraction; it is never read back.
    logic             r_guard_unused;
    assign r_guard_unused = r[WIDTH];

    // One restoring step: shift in the next dividend bit and try a subtract.
    assign shifted_c = {r[WIDTH-1:0], q[WIDTH-1]};

    subtractor_borrow #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a          (shifted_c),
        .b          ({1'b0, divisor_r}),
        .diff       (diff_c),
        .borrow_out (borrow_c)
    );

    assign r_next_c = borrow_c ? shifted_c : diff_c;
    assign q_next_c = {q[WIDTH-2:0], ~borrow_c};

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            divisor_r   <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        divisor_r   <= divisor;
                        q           <= dividend;
                        r           <= '0;
                        cnt         <= CW'(WIDTH - 1);
                        state       <= CALC;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    if (TRAP_EN && (divisor_r == '0)) begin
                        // q still holds the untouched dividend here.
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= WIDTH'(all_ones(WIDTH));
                        remainder   <= q;
                        div_by_zero <= 1'b1;
                    end else begin
                        r   <= r_next_c;
                        q   <= q_next_c;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= q_next_c;
                            remainder   <= r_next_c[WIDTH-1:0];
                            div_by_zero <= (divisor_r == '0);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_restoring.sv
// Self-checking bench for divider_restoring (WIDTH = 8).
// Reference results come from plain integer / and % in the bench.
module tb_divider_restoring;

    localparam int unsigned W = 8;

`ifdef DIV_ZERO_TRAP_EN
    localparam int unsigned ZERO_LAT = 1;
`else
    localparam int unsigned ZERO_LAT = W;
`endif

    logic         clock;
    logic         resetn;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    divider_restoring #(.WIDTH(W)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain unsigned division, zero divisor gives all-ones / dividend.
    function automatic int unsigned ref_q(input int unsigned a, input int unsigned b);
        return (b == 0) ? (2**W - 1) : a / b;
    endfunction

    function automatic int unsigned ref_r(input int unsigned a, input int unsigned b);
        return (b == 0) ? a : a % b;
    endfunction

    // Present operands with start for one edge; scramble operands afterwards.
    task automatic issue(input int unsigned a, input int unsigned b);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
    endtask

    // Wait (bounded) for done and check latency and results.
    task automatic wait_done(input int unsigned a, input int unsigned b, input int unsigned lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (done === 1'b1) got = 1'b1;
            else check("calc_busy", 32'(busy), 32'd1);
        end
        check("latency", 32'(n), 32'(lat));
        check("quotient", 32'(quotient), 32'(ref_q(a, b)));
        check("remainder", 32'(remainder), 32'(ref_r(a, b)));
        check("div_by_zero", 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic done_drops();
        @(posedge clock);
        #1;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int unsigned a;
        int unsigned b;

        resetn   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Nominal and edge values.
        issue(200, 7);  wait_done(200, 7, W);  done_drops();
        issue(255, 1);  wait_done(255, 1, W);  done_drops();
        issue(5, 9);    wait_done(5, 9, W);    done_drops();
        issue(255, 255); wait_done(255, 255, W); done_drops();
        issue(100, 0);  wait_done(100, 0, ZERO_LAT); done_drops();

        // start during CALC is ignored.
        issue(200, 7);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        dividend = 8'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(200, 7, W - 3);

        // Back-to-back issue from DONE without an idle cycle.
        issue(50, 3);
        wait_done(50, 3, W);
        done_drops();

        // Asynchronous reset mid-operation.
        issue(200, 7);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", 32'(quotient), 32'd0);
        check("midrst_r", 32'(remainder), 32'd0);
        check("midrst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        issue(9, 2);
        wait_done(9, 2, W);
        done_drops();

        // Result held while idle.
        issue(200, 7);
        wait_done(200, 7, W);
        repeat (20) begin
            @(posedge clock);
            #1;
            check("hold_q", 32'(quotient), 32'd28);
            check("hold_r", 32'(remainder), 32'd4);
            check("hold_done", 32'(done), 32'd0);
        end

        // Random operands, mixing idle gaps and back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 2**W - 1);
            b = (i % 6 == 0) ? 0 : $urandom_range(0, 2**W - 1);
            issue(a, b);
            wait_done(a, b, (b == 0) ? ZERO_LAT : W);
            if ($urandom_range(0, 1) == 1) done_drops();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
